// File: rtl/async_queue_enq_arbiter_pkg.sv
// Shared types and helpers for the async-queue enqueue arbiter.
package async_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned QUEUE_W = 32;

  // Counter width helper; never returns zero so single-value counters still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/async_queue_enq_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request mask to start at rr_ptr, then take the lowest set bit.
module rr_pick
  import async_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);

  logic [ID_W:0]      pos [N_REQ];
  logic [N_REQ-1:0]   rot;

  // Modular add without '%' so N_REQ need not be a power of two.
  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos[k] = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (pos[k] >= (ID_W+1)'(N_REQ)) begin
        pos[k] = pos[k] - (ID_W+1)'(N_REQ);
      end
      rot[k] = req[pos[k][ID_W-1:0]];
    end
  end

  always_comb begin
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (rot[k] && !grant_vld) begin
        grant_vld = 1'b1;
        grant_id  = pos[k][ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/async_queue_enq_arbiter.sv
// Packet-granular round-robin arbiter feeding one async-queue enqueue port; tags each beat with the requester ID.
module async_queue_enq_arbiter
  import async_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned DATA_W    = 30,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_bits,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    enq_valid,
  output logic [DATA_W+ID_W-1:0]  enq_bits,
  input  logic                    enq_ready,
  input  logic                    arb_enable,
  output logic                    arb_idle,
  output logic                    err_overlong
);

  localparam int unsigned         CNT_W   = clog2_min1(MAX_BEATS);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]     ID_LAST = ID_W'(N_REQ - 1);

  arb_state_e         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    lock_id;
  logic [CNT_W-1:0]   beat_cnt;

  logic [ID_W-1:0]    pick_id;
  logic               pick_vld;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_bits;
  logic               fire;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_id  (pick_id),
    .grant_vld (pick_vld)
  );

  // Reset gates the grant so every downstream output is quiet while reset is held.
  always_comb begin
    grant_id  = '0;
    grant_vld = 1'b0;
    if (!reset) begin
      if (state == ARB_LOCKED) begin
        grant_id  = lock_id;
        grant_vld = 1'b1;
      end else if (arb_enable) begin
        grant_id  = pick_id;
        grant_vld = pick_vld;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_bits  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_bits     = req_bits[i*DATA_W +: DATA_W];
        req_ready[i] = enq_ready & grant_vld;
      end
    end
  end

  assign enq_valid = grant_vld & sel_valid;
  assign enq_bits  = {grant_id, sel_bits};
  assign fire      = enq_valid & enq_ready;
  assign arb_idle  = ~reset & (state == ARB_IDLE) & ~(grant_vld & enq_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      lock_id      <= '0;
      beat_cnt     <= '0;
      err_overlong <= 1'b0;
    end else if (fire) begin
      if (sel_last) begin
        state    <= ARB_IDLE;
        rr_ptr   <= (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
        beat_cnt <= '0;
      end else begin
        state   <= ARB_LOCKED;
        lock_id <= grant_id;
        // Saturate and flag rather than break the lock; the sink still sees a whole packet.
        if (beat_cnt == CNT_MAX) begin
          err_overlong <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_async_queue_enq_arbiter.sv
// Self-checking bench: directed table, hand sequences for lock/stall/drain/overlong, and random traffic vs a reference model.
module tb_async_queue_enq_arbiter;

  localparam int N    = 4;
  localparam int DW   = 30;
  localparam int MAXB = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_bits;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            enq_valid;
  logic [DW+1:0]   enq_bits;
  logic            enq_ready;
  logic            arb_enable;
  logic            arb_idle;
  logic            err_overlong;

  async_queue_enq_arbiter #(
    .N_REQ     (N),
    .ID_W      (2),
    .DATA_W    (DW),
    .MAX_BEATS (MAXB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_bits     (req_bits),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .enq_valid    (enq_valid),
    .enq_bits     (enq_bits),
    .enq_ready    (enq_ready),
    .arb_enable   (arb_enable),
    .arb_idle     (arb_idle),
    .err_overlong (err_overlong)
  );

  always #5 clock = ~clock;

  // Reference model: owner of the open packet (-1 = none), next preferred requester, beats so far.
  int   m_rr   = 0;
  int   m_lock = -1;
  int   m_cnt  = 0;
  bit   m_err  = 1'b0;
  bit   m_fired;
  int   m_fgid;

  bit          e_gv, e_ev, e_idle;
  int          e_gid;
  logic [N-1:0] e_ready;
  logic [31:0] e_bits;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    e_gv = 1'b0;
    e_gid = 0;
    if (reset) begin
      e_ev = 1'b0; e_ready = '0; e_idle = 1'b0; e_bits = '0;
      return;
    end
    if (m_lock >= 0) begin
      e_gv = 1'b1; e_gid = m_lock;
    end else if (arb_enable) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!e_gv && req_valid[c]) begin e_gv = 1'b1; e_gid = c; end
      end
    end
    e_ev    = e_gv && req_valid[e_gid];
    e_ready = (e_gv && enq_ready) ? N'(1 << e_gid) : '0;
    e_idle  = (m_lock < 0) && !e_ev;
    e_bits  = {2'(e_gid), req_bits[e_gid*DW +: DW]};
  endtask

  task automatic model_step();
    m_fired = !reset && e_ev && enq_ready;
    m_fgid  = e_gid;
    if (reset) begin
      m_rr = 0; m_lock = -1; m_cnt = 0; m_err = 1'b0;
    end else if (m_fired) begin
      if (req_last[e_gid]) begin
        m_lock = -1; m_rr = (e_gid + 1) % N; m_cnt = 0;
      end else begin
        m_lock = e_gid;
        if (m_cnt == MAXB - 1) m_err = 1'b1;
        else m_cnt++;
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clock);
    model_eval();
  endtask

  task automatic to_next();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_enq_valid"}, 32'(enq_valid), 32'(e_ev));
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(e_ready));
    chk({tag, "_arb_idle"}, 32'(arb_idle), 32'(e_idle));
    chk({tag, "_err"}, 32'(err_overlong), 32'(m_err));
    if (e_ev) chk({tag, "_enq_bits"}, enq_bits, e_bits);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         rdy;
    logic         en;
    logic         ev;
    int           id;
    logic [N-1:0] ready;
    logic         idle;
  } vec_t;

  vec_t tbl [8];
  int   rem [N];

  initial begin
    reset = 1'b1; req_valid = '1; req_last = '1; enq_ready = 1'b1; arb_enable = 1'b1;
    for (int i = 0; i < N; i++) req_bits[i*DW +: DW] = 30'(32'h0A00_0000 + i * 32'h111);

    // Reset held with all requesters valid.
    for (int c = 0; c < 3; c++) begin
      to_neg();
      check_model("rst");
      chk("rst_enq_valid", 32'(enq_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_arb_idle", 32'(arb_idle), 0);
      to_next();
    end
    reset = 1'b0;

    // Single-beat packets from reset state (rr_ptr starts at 0).
    tbl[0] = '{4'b1111, 1'b0, 1'b1, 1'b1, 0, 4'b0000, 1'b0};
    tbl[1] = '{4'b0110, 1'b0, 1'b1, 1'b1, 1, 4'b0000, 1'b0};
    tbl[2] = '{4'b0000, 1'b1, 1'b1, 1'b0, 0, 4'b0000, 1'b1};
    tbl[3] = '{4'b1111, 1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b1};
    tbl[4] = '{4'b1100, 1'b1, 1'b1, 1'b1, 2, 4'b0100, 1'b0};
    tbl[5] = '{4'b0101, 1'b1, 1'b1, 1'b1, 0, 4'b0001, 1'b0};
    tbl[6] = '{4'b1001, 1'b1, 1'b1, 1'b1, 3, 4'b1000, 1'b0};
    tbl[7] = '{4'b0010, 1'b0, 1'b1, 1'b1, 1, 4'b0000, 1'b0};
    for (int v = 0; v < 8; v++) begin
      req_valid = tbl[v].valid; enq_ready = tbl[v].rdy; arb_enable = tbl[v].en; req_last = '1;
      to_neg();
      check_model("tbl");
      chk($sformatf("tbl%0d_enq_valid", v), 32'(enq_valid), 32'(tbl[v].ev));
      chk($sformatf("tbl%0d_req_ready", v), 32'(req_ready), 32'(tbl[v].ready));
      chk($sformatf("tbl%0d_arb_idle", v), 32'(arb_idle), 32'(tbl[v].idle));
      if (tbl[v].ev) chk($sformatf("tbl%0d_id", v), 32'(enq_bits[31:30]), 32'(tbl[v].id));
      to_next();
    end

    // Fairness: continuous single-beat packets from everyone.
    req_valid = '1; req_last = '1; enq_ready = 1'b1; arb_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      to_neg();
      check_model("fair");
      chk("fair_id", 32'(enq_bits[31:30]), k % 4);
      to_next();
    end

    // Lock: move rr_ptr to 1, then req1 sends 3 beats while req0/req2 wait.
    req_valid = 4'b0001;
    to_neg(); check_model("lock_pre"); chk("lock_pre_id", 32'(enq_bits[31:30]), 0); to_next();
    req_valid = 4'b0111; req_last = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) req_last[1] = 1'b1;
      req_bits[DW +: DW] = 30'($urandom);
      to_neg(); check_model("lock"); chk("lock_id", 32'(enq_bits[31:30]), 1); to_next();
    end
    to_neg(); check_model("lock_after"); chk("lock_after_id", 32'(enq_bits[31:30]), 2); to_next();

    // Backpressure mid-packet of req3 (rr_ptr now 3).
    req_valid = '1; req_last = '0;
    to_neg(); check_model("bp_b1"); chk("bp_b1_id", 32'(enq_bits[31:30]), 3); to_next();
    enq_ready = 1'b0;
    req_bits[3*DW +: DW] = 30'h1234567;
    for (int c = 0; c < 5; c++) begin
      req_bits[0 +: DW] = 30'($urandom);
      to_neg();
      check_model("bp_stall");
      chk("bp_stall_bits", enq_bits, {2'd3, 30'h1234567});
      chk("bp_stall_ready", 32'(req_ready), 0);
      to_next();
    end

    // Drain: disable mid-packet; req3 must still finish, then nothing new.
    enq_ready = 1'b1; arb_enable = 1'b0;
    to_neg(); check_model("drain_b2"); chk("drain_b2_id", 32'(enq_bits[31:30]), 3); to_next();
    req_last[3] = 1'b1;
    to_neg(); check_model("drain_b3"); chk("drain_b3_ready", 32'(req_ready), 32'h8); to_next();
    for (int c = 0; c < 4; c++) begin
      to_neg();
      check_model("drain_idle");
      chk("drain_arb_idle", 32'(arb_idle), 1);
      chk("drain_enq_valid", 32'(enq_valid), 0);
      to_next();
    end
    req_last = '1; arb_enable = 1'b1;
    to_neg(); check_model("drain_resume"); chk("drain_resume_id", 32'(enq_bits[31:30]), 0); to_next();

    // Overlong: req2 sends 17 non-last beats, then a last beat.
    req_valid = 4'b0100; req_last = '0;
    for (int b = 1; b <= 17; b++) begin
      to_neg();
      check_model("ovl");
      chk("ovl_id", 32'(enq_bits[31:30]), 2);
      chk($sformatf("ovl_err_b%0d", b), 32'(err_overlong), 32'(b >= 17));
      to_next();
      req_valid = '1;
    end
    req_last = 4'b0100;
    to_neg(); check_model("ovl_last"); chk("ovl_last_id", 32'(enq_bits[31:30]), 2); to_next();
    req_last = '1;
    to_neg(); check_model("ovl_after"); chk("ovl_after_err", 32'(err_overlong), 1);
    chk("ovl_after_id", 32'(enq_bits[31:30]), 3); to_next();
    reset = 1'b1;
    to_neg(); check_model("ovl_rst"); to_next();
    reset = 1'b0;
    to_neg(); check_model("ovl_clr"); chk("ovl_clr_err", 32'(err_overlong), 0); to_next();

    // Random packet traffic, requesters honour hold-until-accepted.
    req_valid = '0;
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 20);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_fired && m_fgid == i) begin
          req_valid[i] = 1'b0;
          rem[i]--;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 20);
        end
        if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
          req_valid[i] = 1'b1;
          req_last[i]  = (rem[i] == 1);
          req_bits[i*DW +: DW] = 30'($urandom);
        end
      end
      enq_ready  = ($urandom_range(0, 3) != 0);
      arb_enable = ($urandom_range(0, 7) != 0);
      reset      = ($urandom_range(0, 299) == 0);
      to_neg();
      check_model("rnd");
      to_next();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
